// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD adder: FSM state encoding and
// BCD digit constants (digit width, largest legal digit, decimal correction).
package bcd_pkg;

   localparam int unsigned BCD_W    = 4;
   localparam int unsigned BCD_MAX  = 9;
   localparam int unsigned BCD_CORR = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder (combinational).
// Ports:
//   x, y : BCD digits to add
//   ci   : decimal carry in
//   s    : BCD sum digit
//   co   : decimal carry out
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] x,
   input  logic [BCD_W-1:0] y,
   input  logic             ci,
   output logic [BCD_W-1:0] s,
   output logic             co
);

   logic [BCD_W:0] t;

   // Binary add, then skip the six unused codes when the result exceeds 9.
   always_comb begin
      t  = (BCD_W+1)'(x) + (BCD_W+1)'(y) + (BCD_W+1)'(ci);
      s  = BCD_W'(t);
      co = 1'b0;
      if (t > (BCD_W+1)'(BCD_MAX)) begin
         s  = BCD_W'(t + (BCD_W+1)'(BCD_CORR));
         co = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_seq_adder_ctrl.sv
// Digit-serial packed-BCD adder: one digit per clock through a single
// bcd_digit_add, with a valid/ready handshake on both sides.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   a, b, cin           : packed BCD operands (digit 0 in bits [3:0]), carry in
//   out_valid, out_ready: result handshake (result held in DONE)
//   sum, cout, err      : packed BCD sum, decimal carry out, non-BCD digit flag
// Build option: define BCD_DIGIT_CHECK_EN to enable the non-BCD digit check;
// otherwise err is tied low.
module bcd_seq_adder_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned NDIGITS = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BCD_W*NDIGITS-1:0] a,
   input  logic [BCD_W*NDIGITS-1:0] b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BCD_W*NDIGITS-1:0] sum,
   output logic                     cout,
   output logic                     err
);

   localparam int unsigned DW = BCD_W * NDIGITS;
   localparam int unsigned IW = $clog2(NDIGITS) + 1;

   state_t           state_q, state_nx;
   logic             in_ready_q, in_ready_nx;
   logic             out_valid_q, out_valid_nx;
   logic [DW-1:0]    a_q, b_q, sum_q;
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic [BCD_W-1:0] a_d, b_d, s_d;
   logic             co_d;
   logic             accept;
   logic             last_digit;

   assign accept     = (state_q == IDLE) && in_valid;
   assign last_digit = (idx_q == IW'(NDIGITS - 1));
   assign a_d        = a_q[idx_q*BCD_W +: BCD_W];
   assign b_d        = b_q[idx_q*BCD_W +: BCD_W];

   bcd_digit_add u_digit_add (
      .x  (a_d),
      .y  (b_d),
      .ci (carry_q),
      .s  (s_d),
      .co (co_d)
   );

   // State and handshake register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_nx;
         in_ready_q  <= in_ready_nx;
         out_valid_q <= out_valid_nx;
      end
   end

   // Next state; handshake flags are decoded from the next state so they
   // come out of flops aligned with the state they describe.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (in_valid)   state_nx = RUN;
         RUN:     if (last_digit) state_nx = DONE;
         DONE:    if (out_ready)  state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
      in_ready_nx  = (state_nx == IDLE);
      out_valid_nx = (state_nx == DONE);
   end

   // Operand capture and digit-serial accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         sum_q   <= '0;
         carry_q <= cin;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         sum_q[idx_q*BCD_W +: BCD_W] <= s_d;
         carry_q                     <= co_d;
         idx_q                       <= idx_q + IW'(1);
      end
   end

`ifdef BCD_DIGIT_CHECK_EN
   logic err_q;
   logic bad_digit;

   assign bad_digit = (a_d > BCD_W'(BCD_MAX)) || (b_d > BCD_W'(BCD_MAX));

   // Sticky non-BCD flag, cleared for each new operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (state_q == RUN) begin
         err_q <= err_q | bad_digit;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = carry_q;

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Directed self-checking bench for bcd_seq_adder_ctrl with NDIGITS=4.
module tb_bcd_seq_adder_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        err;

   int checks;
   int failures;

   bcd_seq_adder_ctrl #(.NDIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one operand pair in IDLE, scramble the inputs right after the
   // accept edge, and return the number of edges until out_valid (-1 on timeout).
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, output int lat);
      int n;
      lat = -1;
      n   = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      a = av; b = bv; cin = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b err=%b, expected 1 0 0000 0 0",
                  in_ready, out_valid, sum, cout, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      int lat;
      run_op(16'h1234, 16'h5678, 1'b0, lat);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL basic_latency: got %0d, expected 4", lat);
      end
      checks++;
      if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: sum=%h cout=%b err=%b in_ready=%b, expected 6912 0 0 0",
                  sum, cout, err, in_ready);
      end
      handoff();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_handoff: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_carry();
      int lat;
      run_op(16'h9999, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 4 || sum !== 16'h0000 || cout !== 1'b1) begin
         failures++;
         $display("FAIL carry_9999: lat=%0d sum=%h cout=%b, expected 4 0000 1", lat, sum, cout);
      end
      handoff();
      run_op(16'h0000, 16'h0000, 1'b1, lat);
      checks++;
      if (lat !== 4 || sum !== 16'h0001 || cout !== 1'b0) begin
         failures++;
         $display("FAIL carry_cin: lat=%0d sum=%h cout=%b, expected 4 0001 0", lat, sum, cout);
      end
      handoff();
      run_op(16'h0999, 16'h0000, 1'b1, lat);
      checks++;
      if (lat !== 4 || sum !== 16'h1000 || cout !== 1'b0) begin
         failures++;
         $display("FAIL carry_ripple: lat=%0d sum=%h cout=%b, expected 4 1000 0", lat, sum, cout);
      end
      handoff();
   endtask

   task automatic test_hold();
      int lat;
      run_op(16'h1234, 16'h5678, 1'b0, lat);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h6912 || cout !== 1'b0) begin
            failures++;
            $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b sum=%h cout=%b, expected 1 0 6912 0",
                     i, out_valid, in_ready, sum, cout);
         end
      end
      in_valid = 1'b0;
      handoff();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sum !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || cout !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: sum=%h out_valid=%b in_ready=%b cout=%b err=%b, expected 0000 0 1 0 0",
                  sum, out_valid, in_ready, cout, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_discard: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
      run_op(16'h0005, 16'h0005, 1'b0, lat);
      checks++;
      if (lat !== 4 || sum !== 16'h0010 || cout !== 1'b0) begin
         failures++;
         $display("FAIL reset_recover: lat=%0d sum=%h cout=%b, expected 4 0010 0", lat, sum, cout);
      end
      handoff();
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(16'h0042, 16'h0058, 1'b0, lat);
      a = 16'h0042; b = 16'h0058; cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
      a = 16'h0321; b = 16'h0679; cin = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: in_ready=%b, expected 0", in_ready);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 4 || sum !== 16'h1001 || cout !== 1'b0) begin
         failures++;
         $display("FAIL b2b_result: lat=%0d sum=%h cout=%b, expected 4 1001 0", lat, sum, cout);
      end
      handoff();
   endtask

`ifdef BCD_DIGIT_CHECK_EN
   task automatic test_digit_check();
      int lat;
      run_op(16'h12A4, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 4 || err !== 1'b1) begin
         failures++;
         $display("FAIL check_bad: lat=%0d err=%b, expected 4 1", lat, err);
      end
      handoff();
      run_op(16'h0001, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 4 || err !== 1'b0 || sum !== 16'h0002) begin
         failures++;
         $display("FAIL check_clean: lat=%0d err=%b sum=%h, expected 4 0 0002", lat, err, sum);
      end
      handoff();
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      rst_n     = 1'b1;
      #2;
      test_reset();
      test_basic();
      test_carry();
      test_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef BCD_DIGIT_CHECK_EN
      test_digit_check();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
